add_sched: RTL and testbench

ADD_SCHED -- requirements
Module: add_sched

---
 rtl/add_sched_pkg.sv | 19 +
 rtl/adder_4.sv | 27 ++
 rtl/add_sched.sv | 117 +++++++++++
 tb/tb_add_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sched_pkg.sv
// rtl/add_sched_pkg.sv - shared types and sizing constants for the serial add/sub scheduler
package add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for a given nibble count; never narrower than one bit
    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

    localparam int ADD_WIDTH = 16;
    localparam int NIBBLES   = ADD_WIDTH / 4;
    localparam int CNT_W     = cnt_width(NIBBLES);

endpackage

// File: rtl/adder_4.sv
// rtl/adder_4.sv - 4-bit carry-lookahead adder slice
module adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] f,
    output logic       c4
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    // Generate/propagate lookahead; every carry is a flat sum of products
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        f    = p ^ c;
    end

endmodule

// File: rtl/add_sched.sv
// rtl/add_sched.sv - two-requester round-robin add/sub unit over one shared nibble slice
module add_sched
    import add_sched_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [1:0]         req_sub,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_sum,
    output logic               rsp_cout,
    output logic               rsp_ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = cnt_width(NIB);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CW-1:0]    k_q;
    logic             carry_q, id_q, cout_q, ovf_q, rr_q;

    logic [1:0]       grant;
    logic             gid, sub_sel, xfer, last;
    logic [3:0]       nib_a, nib_b, nib_f;
    logic             nib_c4;

    // Arbitration: a lone requester wins outright, a tie goes to the pointer
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = rr_q ? 2'b10 : 2'b01;
        end
    end

    assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
    assign xfer      = |(req_valid & req_ready);
    assign gid       = req_ready[1];
    assign sub_sel   = gid ? req_sub[1] : req_sub[0];
    assign last      = (k_q == CW'(NIB - 1));

    assign nib_a = a_q[{k_q, 2'b00} +: 4];
    assign nib_b = b_q[{k_q, 2'b00} +: 4];

    adder_4 u_slice (
        .a   (nib_a),
        .b   (nib_b),
        .cin (carry_q),
        .f   (nib_f),
        .c4  (nib_c4)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept, run one nibble per cycle, hold result until taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer)      state_nxt = CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, then serial nibble accumulation with flags on the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else if (xfer) begin
            a_q     <= gid ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            b_q     <= (gid ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0]) ^ {WIDTH{sub_sel}};
            carry_q <= sub_sel;
            id_q    <= gid;
            k_q     <= '0;
            rr_q    <= ~gid;
        end else if (state == CALC) begin
            sum_q[{k_q, 2'b00} +: 4] <= nib_f;
            carry_q <= nib_c4;
            k_q     <= k_q + CW'(1);
            if (last) begin
                cout_q <= nib_c4;
                // carry into the MSB recovered from the sum bit and its operands
                ovf_q  <= nib_f[3] ^ nib_a[3] ^ nib_b[3] ^ nib_c4;
            end
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_add_sched.sv
// tb/tb_add_sched.sv - scoreboard bench for add_sched
module tb_add_sched;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_sub;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           rsp_ovf;

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    add_sched #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub);
        exp_t        e;
        logic [W:0]  s;
        s      = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (W+1)'(sub);
        e.id   = id;
        e.sum  = s[W-1:0];
        e.cout = s[W];
        if (sub) e.ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        else     e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic exp_t mk(input logic id, input logic [W-1:0] sum, input logic cout,
                                input logic ovf);
        exp_t e;
        e.id = id; e.sum = sum; e.cout = cout; e.ovf = ovf;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub);
        int n;
        req_valid          = 2'b00;
        req_valid[id]      = 1'b1;
        req_a[id*W +: W]   = a;
        req_b[id*W +: W]   = b;
        req_sub[id]        = sub;
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("grant_wait", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
    endtask

    task automatic wait_rsp(input bit scramble, output int lat);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            check("busy_ready", 32'(req_ready), 32'd0);
            if (scramble) begin
                req_a   = $urandom;
                req_b   = $urandom;
                req_sub = 2'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        check("rsp_wait", 32'(n < 40), 32'd1);
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        check({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_id"},    32'(rsp_id),    32'(e.id));
            check({tag, "_sum"},   32'(rsp_sum),   32'(e.sum));
            check({tag, "_cout"},  32'(rsp_cout),  32'(e.cout));
            check({tag, "_ovf"},   32'(rsp_ovf),   32'(e.ovf));
            check({tag, "_rdy"},   32'(req_ready), 32'd0);
        end
    endtask

    task automatic run_one(input string tag, input logic id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic sub, input exp_t e);
        int lat;
        sb.push_back(e);
        issue(id, a, b, sub);
        wait_rsp(1'b1, lat);
        check_rsp(tag);
        @(posedge clk); #1;
        check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int   lat;
        logic id;
        logic [W-1:0] ra, rb;
        logic rs;

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_a     = {16'h5000, 16'h1111};
        req_b     = {16'h0123, 16'h2222};
        req_sub   = 2'b10;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id",    32'(rsp_id),    32'd0);
        check("rst_sum",   32'(rsp_sum),   32'd0);
        check("rst_cout",  32'(rsp_cout),  32'd0);
        check("rst_ovf",   32'(rsp_ovf),   32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;

        // both held valid: grants alternate starting from requester 0
        for (int g = 0; g < 4; g++) begin
            id = 1'(g % 2);
            check("rr_grant", 32'(req_ready), id ? 32'd2 : 32'd1);
            sb.push_back(id ? model(1'b1, 16'h5000, 16'h0123, 1'b1)
                            : model(1'b0, 16'h1111, 16'h2222, 1'b0));
            @(posedge clk); #1;
            wait_rsp(1'b0, lat);
            check_rsp("rr_rsp");
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        #1;

        // first vector also pins the response latency
        sb.push_back(mk(1'b0, 16'h2233, 1'b0, 1'b0));
        issue(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        wait_rsp(1'b1, lat);
        check("latency", 32'(lat), 32'd4);
        check_rsp("add0");
        @(posedge clk); #1;
        check("add0_drop", 32'(rsp_valid), 32'd0);

        run_one("sub1",  1'b1, 16'h0000, 16'h0001, 1'b1, mk(1'b1, 16'hFFFF, 1'b0, 1'b0));
        run_one("ovfa",  1'b0, 16'h7FFF, 16'h0001, 1'b0, mk(1'b0, 16'h8000, 1'b0, 1'b1));
        run_one("ovfs",  1'b1, 16'h8000, 16'h0001, 1'b1, mk(1'b1, 16'h7FFF, 1'b1, 1'b1));
        run_one("wrap",  1'b0, 16'hFFFF, 16'hFFFF, 1'b0, mk(1'b0, 16'hFFFE, 1'b1, 1'b0));

        // consumer stalls three cycles in DONE while the other requester waits
        rsp_ready = 1'b0;
        sb.push_back(mk(1'b1, 16'h0100, 1'b0, 1'b0));
        issue(1'b1, 16'h00FF, 16'h0001, 1'b0);
        req_valid = 2'b01;
        req_a[W-1:0] = 16'h0001;
        req_b[W-1:0] = 16'h0001;
        req_sub[0]   = 1'b0;
        wait_rsp(1'b0, lat);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_sum",   32'(rsp_sum),   32'h0100);
            check("stall_id",    32'(rsp_id),    32'd1);
            check("stall_rdy",   32'(req_ready), 32'd0);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        #1;
        check_rsp("stall");
        @(posedge clk); #1;
        check("stall_drop", 32'(rsp_valid), 32'd0);

        for (int r = 0; r < 6; r++) begin
            id = 1'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            run_one("rand", id, ra, rb, rs, model(id, ra, rb, rs));
        end

        run_one("pre_abort", 1'b1, 16'hA5A5, 16'h1111, 1'b0, mk(1'b1, 16'hB6B6, 1'b0, 1'b0));

        // reset lands in the second CALC cycle; the in-flight op must vanish
        issue(1'b1, 16'h1234, 16'h4321, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_sum",   32'(rsp_sum),   32'd0);
        check("abort_id",    32'(rsp_id),    32'd0);
        check("abort_cout",  32'(rsp_cout),  32'd0);
        check("abort_ovf",   32'(rsp_ovf),   32'd0);
        check("abort_rdy",   32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("abort_quiet", 32'(rsp_valid), 32'd0);
        end
        run_one("post_abort", 1'b0, 16'h0F0F, 16'h0101, 1'b1, mk(1'b0, 16'h0E0E, 1'b1, 1'b0));

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
